// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv2d output path.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package conv_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam int SAT_W = 64;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp a sign-extended value into the range of an out_w-bit signed number.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantizes one element: optional ReLU, arithmetic right shift, signed saturation.
// Latency: purely combinational.
// Backpressure: not applicable.
module requant_sat
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_DATA_WIDTH = 8,
    parameter int SHIFT          = 0,
    parameter int RELU_EN        = 1
) (
    input  logic signed [DATA_WIDTH-1:0]     x,
    output logic signed [OUT_DATA_WIDTH-1:0] y
);

    logic signed [DATA_WIDTH-1:0] xr;
    logic signed [DATA_WIDTH-1:0] xs;

    always_comb begin
        xr = ((RELU_EN != 0) && x[DATA_WIDTH-1]) ? '0 : x;
        xs = xr >>> SHIFT;
        y  = OUT_DATA_WIDTH'(sat_signed(SAT_W'(xs), OUT_DATA_WIDTH));
    end

endmodule

// File: rtl/conv2d_out_streamer.sv
// Captures a whole flattened conv tensor and streams requantized elements one per beat.
// Latency: beat 0 valid the cycle after capture; one beat per cycle with m_ready held high.
// Backpressure: m_valid/m_data/m_index/m_last hold while m_ready is low; in_ready low while streaming.
module conv2d_out_streamer
    import conv_pkg::*;
#(
    parameter int BATCH_SIZE     = 1,
    parameter int OUT_CHANNELS   = 1,
    parameter int OUT_HEIGHT     = 2,
    parameter int OUT_WIDTH      = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int OUT_DATA_WIDTH = 8,
    parameter int SHIFT          = 0,
    parameter int RELU_EN        = 1,
    localparam int N             = BATCH_SIZE * OUT_CHANNELS * OUT_HEIGHT * OUT_WIDTH,
    localparam int IDX_W         = idx_width(N)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*DATA_WIDTH-1:0]   tensor_flat,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [OUT_DATA_WIDTH-1:0] m_data,
    output logic [IDX_W-1:0]          m_index,
    output logic                      m_last,
    output logic                      busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e                      state_q;
    state_e                      state_d;
    logic [DATA_WIDTH-1:0]       tensor_q [N];
    logic [IDX_W-1:0]            nxt_idx;
    logic [IDX_W-1:0]            sel_idx;
    logic signed [DATA_WIDTH-1:0]     rq_x;
    logic signed [OUT_DATA_WIDTH-1:0] rq_y;
    logic                        capture;
    logic                        advance;
    logic                        finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid)                   state_d = ST_STREAM;
            ST_STREAM: if (m_valid && m_ready && m_last) state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
        capture  = in_ready && in_valid;
        advance  = (state_q == ST_STREAM) && m_valid && m_ready && !m_last;
        finish   = (state_q == ST_STREAM) && m_valid && m_ready && m_last;
    end

    // Beat 0 comes straight off the input bus since the buffer is written on the same edge.
    always_comb begin
        nxt_idx = m_index + 1'b1;
        sel_idx = (m_index == LAST_IDX) ? '0 : nxt_idx;
        rq_x    = in_ready ? $signed(tensor_flat[DATA_WIDTH-1:0]) : $signed(tensor_q[sel_idx]);
    end

    requant_sat #(
        .DATA_WIDTH     (DATA_WIDTH),
        .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
        .SHIFT          (SHIFT),
        .RELU_EN        (RELU_EN)
    ) u_requant (
        .x (rq_x),
        .y (rq_y)
    );

    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++)
                tensor_q[i] <= tensor_flat[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= (state_d == ST_STREAM);
            if (capture) begin
                m_valid <= 1'b1;
                m_data  <= rq_y;
                m_index <= '0;
                m_last  <= (N == 1);
            end else if (advance) begin
                m_data  <= rq_y;
                m_index <= nxt_idx;
                m_last  <= (nxt_idx == LAST_IDX);
            end else if (finish) begin
                m_valid <= 1'b0;
                m_index <= '0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_out_streamer.sv
// Bench for conv2d_out_streamer: three parameterizations share one clock and reset.
// Instance 0: defaults (ReLU, shift 0); 1: shift 2 no ReLU; 2: single element, no ReLU.
module tb_conv2d_out_streamer;

    logic        clk;
    logic        rst_n;
    logic        in_valid [3];
    logic        in_ready [3];
    logic        m_valid  [3];
    logic        m_ready  [3];
    logic        m_last   [3];
    logic        busy     [3];
    logic [7:0]  m_data   [3];
    logic [1:0]  idx_ab   [2];
    logic        idx_c;
    logic [127:0] tf      [2];
    logic [31:0] tf_c;

    int total;
    int bad;

    conv2d_out_streamer u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .tensor_flat(tf[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_data(m_data[0]), .m_index(idx_ab[0]), .m_last(m_last[0]), .busy(busy[0])
    );

    conv2d_out_streamer #(.SHIFT(2), .RELU_EN(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .tensor_flat(tf[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_data(m_data[1]), .m_index(idx_ab[1]), .m_last(m_last[1]), .busy(busy[1])
    );

    conv2d_out_streamer #(.OUT_HEIGHT(1), .OUT_WIDTH(1), .RELU_EN(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .tensor_flat(tf_c), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
        .m_data(m_data[2]), .m_index(idx_c), .m_last(m_last[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int sel;
        int t [4];
        int e [4];
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int get_idx(input int sel);
        if (sel == 2) return int'(idx_c);
        return int'(idx_ab[sel]);
    endfunction

    function automatic int n_of(input int sel);
        return (sel == 2) ? 1 : 4;
    endfunction

    // Reference: ReLU, floor division by 2^shift, clamp to int8.
    function automatic int model(input int sel, input int x);
        int sh;
        int d;
        int v;
        sh = (sel == 1) ? 2 : 0;
        v  = x;
        if (sel == 0 && v < 0) v = 0;
        d = 1 << sh;
        if (v >= 0) v = v / d;
        else        v = -((-v + d - 1) / d);
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic set_tensor(input int sel, input int t [4]);
        if (sel == 2) begin
            tf_c = t[0];
        end else begin
            for (int i = 0; i < 4; i++)
                tf[sel][i*32 +: 32] = t[i];
        end
    endtask

    task automatic scramble(input int sel);
        int g [4];
        for (int i = 0; i < 4; i++) g[i] = int'($urandom);
        set_tensor(sel, g);
    endtask

    // Capture one tensor, then drain it; rnd selects a random m_ready pattern.
    task automatic run(input int sel, input int t [4], input int e [4], input bit rnd, input string nm);
        int n;
        int beat;
        int cyc;
        bit r;
        n = n_of(sel);
        beat = 0;
        cyc = 0;
        @(negedge clk);
        chk($sformatf("%s_in_ready_idle", nm), in_ready[sel], 1);
        set_tensor(sel, t);
        in_valid[sel] = 1'b1;
        m_ready[sel]  = 1'b0;
        @(negedge clk);
        in_valid[sel] = 1'b0;
        scramble(sel);
        while (beat < n && cyc < 300) begin
            chk($sformatf("%s_valid_b%0d", nm, beat), m_valid[sel], 1);
            if (!m_valid[sel]) break;
            chk($sformatf("%s_data_b%0d", nm, beat), $signed(m_data[sel]), e[beat]);
            chk($sformatf("%s_idx_b%0d", nm, beat), get_idx(sel), beat);
            chk($sformatf("%s_last_b%0d", nm, beat), m_last[sel], (beat == n - 1) ? 1 : 0);
            chk($sformatf("%s_busy_b%0d", nm, beat), busy[sel], 1);
            chk($sformatf("%s_in_ready_busy", nm), in_ready[sel], 0);
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready[sel] = r;
            if (r) beat++;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("%s_beats_done", nm), beat, n);
        chk($sformatf("%s_valid_after", nm), m_valid[sel], 0);
        chk($sformatf("%s_in_ready_after", nm), in_ready[sel], 1);
        chk($sformatf("%s_busy_after", nm), busy[sel], 0);
        chk($sformatf("%s_idx_after", nm), get_idx(sel), 0);
        chk($sformatf("%s_last_after", nm), m_last[sel], 0);
        m_ready[sel] = 1'b0;
    endtask

    initial begin
        vec_t tbl [6];
        int ta [4];
        int tb [4];
        int tr [4];
        int er [4];
        int sel;

        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            in_valid[s] = 1'b0;
            m_ready[s]  = 1'b0;
        end
        tf[0] = '0;
        tf[1] = '0;
        tf_c  = '0;
        #1 rst_n = 1'b0;
        #2;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_valid_%0d", s), m_valid[s], 0);
            chk($sformatf("rst_data_%0d", s), m_data[s], 0);
            chk($sformatf("rst_idx_%0d", s), get_idx(s), 0);
            chk($sformatf("rst_last_%0d", s), m_last[s], 0);
            chk($sformatf("rst_busy_%0d", s), busy[s], 0);
            chk($sformatf("rst_in_ready_%0d", s), in_ready[s], 1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{0, '{5, -3, 300, 64},        '{5, 0, 127, 64}};
        tbl[1] = '{1, '{-9, 1023, -1024, 7},    '{-3, 127, -128, 1}};
        tbl[2] = '{2, '{-200, 0, 0, 0},         '{-128, 0, 0, 0}};
        tbl[3] = '{0, '{-1, 128, 127, -128},    '{0, 127, 127, 0}};
        tbl[4] = '{1, '{-512, -513, 511, 512},  '{-128, -128, 127, 127}};
        tbl[5] = '{1, '{-1, -4, -5, 3},         '{-1, -1, -2, 0}};
        for (int v = 0; v < 6; v++)
            run(tbl[v].sel, tbl[v].t, tbl[v].e, 1'b0, $sformatf("vec%0d", v));

        // Second tensor offered during beat 1 must wait for the IDLE cycle.
        ta = '{1, 2, 3, 4};
        tb = '{10, -5, 200, 33};
        @(negedge clk);
        set_tensor(0, ta);
        in_valid[0] = 1'b1;
        m_ready[0]  = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        chk("blk_a0", $signed(m_data[0]), 1);
        @(negedge clk);
        chk("blk_a1", $signed(m_data[0]), 2);
        set_tensor(0, tb);
        in_valid[0] = 1'b1;
        @(negedge clk);
        chk("blk_a2", $signed(m_data[0]), 3);
        chk("blk_in_ready_busy", in_ready[0], 0);
        @(negedge clk);
        chk("blk_a3", $signed(m_data[0]), 4);
        chk("blk_a3_last", m_last[0], 1);
        @(negedge clk);
        chk("blk_gap_valid", m_valid[0], 0);
        chk("blk_gap_in_ready", in_ready[0], 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        scramble(0);
        chk("blk_b0_valid", m_valid[0], 1);
        chk("blk_b0_data", $signed(m_data[0]), model(0, tb[0]));
        chk("blk_b0_idx", get_idx(0), 0);
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            chk($sformatf("blk_b%0d_data", b), $signed(m_data[0]), model(0, tb[b]));
            chk($sformatf("blk_b%0d_idx", b), get_idx(0), b);
        end
        @(negedge clk);
        chk("blk_end_valid", m_valid[0], 0);
        m_ready[0] = 1'b0;

        // Reset asserted with two beats delivered drops the tensor at once.
        ta = '{100, 101, 102, 103};
        @(negedge clk);
        set_tensor(0, ta);
        in_valid[0] = 1'b1;
        m_ready[0]  = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_pre_data", $signed(m_data[0]), 102);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", m_valid[0], 0);
        chk("rst_mid_busy", busy[0], 0);
        chk("rst_mid_in_ready", in_ready[0], 1);
        chk("rst_mid_idx", get_idx(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_ready[0] = 1'b0;
        ta = '{1, 2, 3, 4};
        run(0, ta, ta, 1'b0, "post_rst");

        for (int k = 0; k < 15; k++) begin
            sel = k % 3;
            for (int i = 0; i < 4; i++) begin
                tr[i] = int'($urandom_range(0, 4000)) - 2000;
                er[i] = model(sel, tr[i]);
            end
            run(sel, tr, er, 1'b1, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
